// File: rtl/compressor_controller_pkg.sv
// Shared definitions for the compressor ingress controller: beat width,
// FSM encodings and the header-match constants with their bit offsets.
package compressor_controller_pkg;

    localparam int BURST_WIDTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COMPRESS = 3'd1,
        ST_BYPASS   = 3'd2,
        ST_DROP     = 3'd3
    } state_t;

    // Multi-byte fields are compared as they land in little-endian lanes,
    // so big-endian wire values appear byte-swapped here.
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0008;
    localparam logic [15:0] IP_LEN_1500    = 16'hDC05;
    localparam logic [7:0]  BYTE15_VAL     = 8'h28;
    localparam logic [7:0]  PROTO_TCP      = 8'h06;

    localparam int ETHERTYPE_LSB = 96;
    localparam int IP_LEN_LSB    = 128;
    localparam int BYTE15_LSB    = 120;
    localparam int PROTO_LSB     = 184;

endpackage

// File: rtl/compressor_controller_if.sv
// Stream, FIFO and status signals between the ingress controller and its
// surroundings; slave is the controller side, master the driving side.
interface compressor_controller_if;
    import compressor_controller_pkg::*;

    logic                   wrt_en;
    logic                   tvalid;
    logic                   tlast;
    logic                   full_infifo;
    logic                   empty_infifo;
    logic [BURST_WIDTH-1:0] data_in;
    logic [2:0]             state;
    logic                   push_infifo;
    logic                   pop_infifo;
    logic                   flag_compression;
    logic                   is_header;

    modport slave (
        input  wrt_en, tvalid, tlast, full_infifo, empty_infifo, data_in,
        output state, push_infifo, pop_infifo, flag_compression, is_header
    );

    modport master (
        output wrt_en, tvalid, tlast, full_infifo, empty_infifo, data_in,
        input  state, push_infifo, pop_infifo, flag_compression, is_header
    );

endinterface

// File: rtl/compressor_controller_header_match.sv
// Combinational classifier: flags a beat whose IPv4/TCP header fields
// identify a full-size 1500-byte packet as compressible.
module compressor_header_match
    import compressor_controller_pkg::*;
(
    input  logic [BURST_WIDTH-1:0] data_in,
    output logic                   match
);

    logic unused_bits;

    assign match = (data_in[ETHERTYPE_LSB +: 16] == ETHERTYPE_IPV4)
                 & (data_in[IP_LEN_LSB    +: 16] == IP_LEN_1500)
                 & (data_in[BYTE15_LSB    +: 8]  == BYTE15_VAL)
                 & (data_in[PROTO_LSB     +: 8]  == PROTO_TCP);

    assign unused_bits = ^{data_in[BURST_WIDTH-1:192], data_in[183:144],
                           data_in[119:112], data_in[95:0]};

endmodule

// File: rtl/compressor_controller.sv
// Ingress FSM: classifies packets on their header beat, strobes the input
// FIFO, follows tlast boundaries and discards packet tails after overflow.
module compressor_controller
    import compressor_controller_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    compressor_controller_if.slave    bus
);

    state_t state_q;
    state_t state_d;
    logic   acc;
    logic   match;

    compressor_header_match u_header_match (
        .data_in (bus.data_in),
        .match   (match)
    );

    assign acc = bus.tvalid & bus.wrt_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (bus.tlast)            state_d = ST_IDLE;
                    else if (bus.full_infifo) state_d = ST_DROP;
                    else if (match)           state_d = ST_COMPRESS;
                    else                      state_d = ST_BYPASS;
                end
            end
            ST_COMPRESS, ST_BYPASS: begin
                if (acc) begin
                    if (bus.tlast)            state_d = ST_IDLE;
                    else if (bus.full_infifo) state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (acc && bus.tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.is_header        = 1'b0;
        bus.push_infifo      = 1'b0;
        bus.pop_infifo       = 1'b0;
        bus.flag_compression = 1'b0;
        bus.is_header        = (state_q == ST_IDLE) & acc;
        bus.push_infifo      = acc & ~bus.full_infifo & (state_q != ST_DROP);
        bus.pop_infifo       = bus.wrt_en & ~bus.empty_infifo;
        bus.flag_compression = (state_q == ST_COMPRESS) | (bus.is_header & match);
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_compressor_controller.sv
// Directed bench for compressor_controller with a queue-based scoreboard.
module tb_compressor_controller;
    import compressor_controller_pkg::*;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       push;
        logic       pop;
        logic       flag;
        logic       hdr;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    logic [BURST_WIDTH-1:0] hdr_ok;
    logic [BURST_WIDTH-1:0] hdr_bad;
    logic [BURST_WIDTH-1:0] zero_beat;

    compressor_controller_if bus ();

    compressor_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are settled mid-cycle, compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (bus.state !== e.st || bus.push_infifo !== e.push ||
                bus.pop_infifo !== e.pop || bus.flag_compression !== e.flag ||
                bus.is_header !== e.hdr) begin
                n_err++;
                $display("FAIL %s: got state=%0d push=%b pop=%b flag=%b hdr=%b, want state=%0d push=%b pop=%b flag=%b hdr=%b",
                         e.name, bus.state, bus.push_infifo, bus.pop_infifo,
                         bus.flag_compression, bus.is_header,
                         e.st, e.push, e.pop, e.flag, e.hdr);
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic tv,
                        input logic tl, input logic we, input logic fu,
                        input logic em, input logic [BURST_WIDTH-1:0] d,
                        input logic [2:0] st, input logic push, input logic pop,
                        input logic flag, input logic hdr);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst;
        bus.tvalid       = tv;
        bus.tlast        = tl;
        bus.wrt_en       = we;
        bus.full_infifo  = fu;
        bus.empty_infifo = em;
        bus.data_in      = d;
        e.name = name; e.st = st; e.push = push; e.pop = pop; e.flag = flag; e.hdr = hdr;
        exp_q.push_back(e);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        zero_beat = '0;
        hdr_ok = '0;
        hdr_ok[111:96]  = 16'h0008;
        hdr_ok[143:128] = 16'hDC05;
        hdr_ok[127:120] = 8'h28;
        hdr_ok[191:184] = 8'h06;
        reset = 1'b0;
        bus.tvalid = 0; bus.tlast = 0; bus.wrt_en = 0;
        bus.full_infifo = 0; bus.empty_infifo = 1; bus.data_in = '0;

        // Reset held: IDLE combinational behaviour with tvalid high
        step("rst_idle",      0, 1, 0, 1, 0, 1, zero_beat, 0, 1, 0, 0, 1);
        step("rst_idle_hdr",  0, 1, 0, 1, 0, 1, hdr_ok,    0, 1, 0, 1, 1);
        step("rst_release",   1, 0, 0, 1, 0, 1, zero_beat, 0, 0, 0, 0, 0);

        // Compressible packet, pop active throughout
        step("cmp_hdr",       1, 1, 0, 1, 0, 0, hdr_ok,    0, 1, 1, 1, 1);
        for (int i = 0; i < 9; i++)
            step("cmp_body",  1, 1, 0, 1, 0, 0, zero_beat, 1, 1, 1, 1, 0);
        step("cmp_last",      1, 1, 1, 1, 0, 0, zero_beat, 1, 1, 1, 1, 0);
        step("cmp_after",     1, 0, 0, 1, 0, 0, zero_beat, 0, 0, 1, 0, 0);

        // Bypass packet, later matching beats must not reclassify
        step("byp_hdr",       1, 1, 0, 1, 0, 1, zero_beat, 0, 1, 0, 0, 1);
        for (int i = 0; i < 11; i++)
            step("byp_body",  1, 1, 0, 1, 0, 1, hdr_ok,    2, 1, 0, 0, 0);
        step("byp_last",      1, 1, 1, 1, 0, 1, zero_beat, 2, 1, 0, 0, 0);
        step("b2b_hdr",       1, 1, 0, 1, 0, 1, hdr_ok,    0, 1, 0, 1, 1);
        step("b2b_body",      1, 1, 0, 1, 0, 1, zero_beat, 1, 1, 0, 1, 0);

        // Overflow mid-COMPRESS, tail dropped until tlast
        step("ovf_beat",      1, 1, 0, 1, 1, 1, zero_beat, 1, 0, 0, 1, 0);
        step("drop_body",     1, 1, 0, 1, 0, 1, zero_beat, 3, 0, 0, 0, 0);
        step("drop_hdrdata",  1, 1, 0, 1, 0, 1, hdr_ok,    3, 0, 0, 0, 0);
        step("drop_last",     1, 1, 1, 1, 0, 1, zero_beat, 3, 0, 0, 0, 0);
        step("drop_exit",     1, 0, 0, 1, 0, 1, zero_beat, 0, 0, 0, 0, 0);

        // Header lost to a full FIFO
        step("hdr_full",      1, 1, 0, 1, 1, 1, hdr_ok,    0, 0, 0, 1, 1);
        step("hdr_full_last", 1, 1, 1, 1, 0, 1, zero_beat, 3, 0, 0, 0, 0);

        // Single-beat packets, including near-miss headers
        step("single_ok",     1, 1, 1, 1, 0, 1, hdr_ok,    0, 1, 0, 1, 1);
        hdr_bad = hdr_ok; hdr_bad[111:96] = 16'h0800;
        step("miss_ethtype",  1, 1, 1, 1, 0, 1, hdr_bad,   0, 1, 0, 0, 1);
        hdr_bad = hdr_ok; hdr_bad[143:128] = 16'h05DC;
        step("miss_iplen",    1, 1, 1, 1, 0, 1, hdr_bad,   0, 1, 0, 0, 1);
        hdr_bad = hdr_ok; hdr_bad[127:120] = 8'h29;
        step("miss_byte15",   1, 1, 1, 1, 0, 1, hdr_bad,   0, 1, 0, 0, 1);
        hdr_bad = hdr_ok; hdr_bad[191:184] = 8'h11;
        step("miss_proto",    1, 1, 1, 1, 0, 1, hdr_bad,   0, 1, 0, 0, 1);
        step("single_after",  1, 0, 0, 1, 0, 1, zero_beat, 0, 0, 0, 0, 0);

        // wrt_en low stalls everything, then async reset mid-BYPASS
        step("stall_hdr",     1, 1, 0, 1, 0, 0, zero_beat, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            step("stall",     1, 1, 0, 0, 0, 0, hdr_ok,    2, 0, 0, 0, 0);
        step("stall_resume",  1, 1, 0, 1, 0, 0, zero_beat, 2, 1, 1, 0, 0);
        step("async_rst",     0, 1, 0, 1, 0, 0, zero_beat, 0, 1, 1, 0, 1);
        step("post_rst_hdr",  1, 1, 0, 1, 0, 0, hdr_ok,    0, 1, 1, 1, 1);
        step("post_rst_body", 1, 1, 1, 1, 0, 0, zero_beat, 1, 1, 1, 1, 0);
        step("post_rst_idle", 1, 0, 0, 1, 0, 1, zero_beat, 0, 0, 0, 0, 0);

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
